// File: rtl/sram_arb_pkg.sv
// Shared types and width helpers for the sram arbiter.
package sram_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic int ptr_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int hold_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and sram-side signals of the arbiter.
// SRAM_ARB_LOCK_EN adds the per-requester lock input.
interface sram_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    // Handshake: requester i holds req/req_we/req_addr/req_wdata stable while
    // req[i] is high; the access transfers on the rising edge where
    // req[i] & gnt[i], and a read returns rdata one cycle later with rvalid[i].
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
`ifdef SRAM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            lock;
`endif
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          sram_cs;
    logic                          sram_we;
    logic [ADDR_WIDTH-1:0]         sram_addr;
    logic [DATA_WIDTH-1:0]         sram_din;
    logic [DATA_WIDTH-1:0]         sram_dout;
    logic                          busy;

`ifdef SRAM_ARB_LOCK_EN
    modport slave (
        input  req, req_we, req_addr, req_wdata, lock, sram_dout,
        output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din, busy
    );
    modport master (
        output req, req_we, req_addr, req_wdata, lock, sram_dout,
        input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din, busy
    );
`else
    modport slave (
        input  req, req_we, req_addr, req_wdata, sram_dout,
        output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din, busy
    );
    modport master (
        output req, req_we, req_addr, req_wdata, sram_dout,
        input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din, busy
    );
`endif

endinterface

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_picker
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [PTR_W-1:0]   win_idx
);

    always_comb begin
        int   cand;
        logic found;
        cand    = 0;
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        // ptr itself is scanned last so the previous winner has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sram port arbiter with bounded sticky streaks.
// Define SRAM_ARB_LOCK_EN to let a locked owner keep the port indefinitely.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 4
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus,
    output arb_state_t    state_dbg
);

    localparam int PTR_W  = ptr_w(NUM_REQ);
    localparam int HOLD_W = hold_w(MAX_HOLD);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [PTR_W-1:0]   rr_idx, win_idx;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] rr_oh, owner_oh, gnt, rvalid_q;
    logic               others_req, hold_ok, lock_hold, owner_keeps, xfer;
    logic               sram_we_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (rr_oh),
        .win_idx (rr_idx)
    );

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign others_req = |(bus.req & ~owner_oh);
    assign hold_ok    = hold_q < HOLD_W'(MAX_HOLD);

`ifdef SRAM_ARB_LOCK_EN
    assign lock_hold = bus.lock[owner_q];
`else
    assign lock_hold = 1'b0;
`endif

    assign owner_keeps = (state_q == ARB_OWNED) && bus.req[owner_q]
                         && (lock_hold || hold_ok || !others_req);

    // Gated by rst so nothing reaches the sram while reset is asserted.
    assign gnt     = rst ? '0 : (owner_keeps ? owner_oh : rr_oh);
    assign win_idx = owner_keeps ? owner_q : rr_idx;
    assign xfer    = |gnt;

    always_comb begin
        sram_we_c     = 1'b0;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sram_we_c     = bus.req_we[i];
                bus.sram_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus.sram_din  = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        if (xfer) begin
            state_d = ARB_OWNED;
            ptr_d   = win_idx;
            owner_d = win_idx;
            if (state_q == ARB_OWNED && win_idx == owner_q) begin
                hold_d = hold_ok ? hold_q + HOLD_W'(1) : hold_q;
            end else begin
                hold_d = HOLD_W'(1);
            end
        end else begin
            state_d = ARB_IDLE;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            owner_q  <= '0;
            hold_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            rvalid_q <= gnt & {NUM_REQ{~sram_we_c}};
        end
    end

    assign bus.gnt     = gnt;
    assign bus.sram_cs = xfer;
    assign bus.sram_we = sram_we_c;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = bus.sram_dout;
    assign bus.busy    = (|bus.req) | (|rvalid_q);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: two instances (MAX_HOLD 4 and 1) with sram models.
// Covers the lock feature when SRAM_ARB_LOCK_EN is defined.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int EW = 32 + 3 + 8;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    arb_state_t state_a, state_b;

    sram_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(8)) ifa ();
    sram_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(8)) ifb ();

    sram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(8), .MAX_HOLD(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifa),
        .state_dbg (state_a)
    );

    sram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(8), .MAX_HOLD(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifb),
        .state_dbg (state_b)
    );

    // clock / reset / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] preload(input logic [3:0] a);
        return {a, ~a};
    endfunction

    // sram models, synchronous read, latency 1
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= preload(4'(i));
                mem_b[i] <= preload(4'(i));
            end
        end else begin
            if (ifa.sram_cs) begin
                if (ifa.sram_we) mem_a[ifa.sram_addr] <= ifa.sram_din;
                else             ifa.sram_dout <= mem_a[ifa.sram_addr];
            end
            if (ifb.sram_cs) begin
                if (ifb.sram_we) mem_b[ifb.sram_addr] <= ifb.sram_din;
                else             ifb.sram_dout <= mem_b[ifb.sram_addr];
            end
        end
    end

    // scoreboard: {due cycle, rvalid one-hot, rdata}
    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_b[$];
    logic [7:0]    shadow_a [16];
    logic [7:0]    shadow_b [16];
    logic [3:0]    a_addr [3];
    logic [7:0]    a_wdata [3];
    logic [3:0]    b_addr [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (|ifa.rvalid) begin
                if (exp_q_a.size() == 0) begin
                    check("a_rvalid_unexpected", {21'b0, ifa.rvalid, ifa.rdata}, 32'h0);
                end else begin
                    e = exp_q_a.pop_front();
                    check("a_rvalid_cycle", 32'(cyc), e[42:11]);
                    check("a_rvalid_rdata", {21'b0, ifa.rvalid, ifa.rdata}, {21'b0, e[10:0]});
                end
            end else if (exp_q_a.size() != 0 && exp_q_a[0][42:11] == 32'(cyc)) begin
                e = exp_q_a.pop_front();
                check("a_rvalid_missing", {29'b0, ifa.rvalid}, {29'b0, e[10:8]});
            end
            if (|ifb.rvalid) begin
                if (exp_q_b.size() == 0) begin
                    check("b_rvalid_unexpected", {21'b0, ifb.rvalid, ifb.rdata}, 32'h0);
                end else begin
                    e = exp_q_b.pop_front();
                    check("b_rvalid_cycle", 32'(cyc), e[42:11]);
                    check("b_rvalid_rdata", {21'b0, ifb.rvalid, ifb.rdata}, {21'b0, e[10:0]});
                end
            end else if (exp_q_b.size() != 0 && exp_q_b[0][42:11] == 32'(cyc)) begin
                e = exp_q_b.pop_front();
                check("b_rvalid_missing", {29'b0, ifb.rvalid}, {29'b0, e[10:8]});
            end
        end
    endtask

    // driver tasks: apply one cycle of requests, check the grant, log expectations
    task automatic step_a(input logic [2:0] r, input logic [2:0] we, input logic [2:0] exp_gnt,
                          input string name);
        ifa.req    = r;
        ifa.req_we = we;
        for (int i = 0; i < 3; i++) begin
            ifa.req_addr[i*4 +: 4]  = a_addr[i];
            ifa.req_wdata[i*8 +: 8] = a_wdata[i];
        end
        @(negedge clk);
        check(name, {29'b0, ifa.gnt}, {29'b0, exp_gnt});
        for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i]) begin
                if (we[i]) shadow_a[a_addr[i]] = a_wdata[i];
                else exp_q_a.push_back({32'(cyc + 1), exp_gnt, shadow_a[a_addr[i]]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [2:0] r, input logic [2:0] exp_gnt, input string name);
        ifb.req    = r;
        ifb.req_we = 3'b000;
        for (int i = 0; i < 3; i++) ifb.req_addr[i*4 +: 4] = b_addr[i];
        @(negedge clk);
        check(name, {29'b0, ifb.gnt}, {29'b0, exp_gnt});
        for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i]) exp_q_b.push_back({32'(cyc + 1), exp_gnt, shadow_b[b_addr[i]]});
        end
        @(posedge clk);
        #1;
    endtask

`ifdef SRAM_ARB_LOCK_EN
    task automatic set_lock(input logic [2:0] lk);
        ifa.lock = lk;
    endtask
`endif

    initial begin
        rst           = 1'b1;
        mem_load      = 1'b1;
        ifa.req       = '0;
        ifa.req_we    = '0;
        ifa.req_addr  = '0;
        ifa.req_wdata = '0;
        ifb.req       = 3'b111;
        ifb.req_we    = '0;
        ifb.req_addr  = '0;
        ifb.req_wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
        ifa.lock = '0;
        ifb.lock = '0;
`endif
        for (int i = 0; i < 16; i++) begin
            shadow_a[i] = preload(4'(i));
            shadow_b[i] = preload(4'(i));
        end
        for (int i = 0; i < 3; i++) begin
            a_addr[i]  = '0;
            a_wdata[i] = '0;
            b_addr[i]  = 4'(5 + i);
        end
        fork
            monitor();
        join_none

        // reset state, including requests presented during reset
        @(negedge clk);
        check("rst_state_a", {31'b0, state_a}, {31'b0, ARB_IDLE});
        check("rst_gnt_a", {29'b0, ifa.gnt}, 32'h0);
        check("rst_rvalid_a", {29'b0, ifa.rvalid}, 32'h0);
        check("rst_busy_a", {31'b0, ifa.busy}, 32'h0);
        check("rst_gnt_b_req", {29'b0, ifb.gnt}, 32'h0);
        check("rst_cs_b_req", {31'b0, ifb.sram_cs}, 32'h0);
        @(posedge clk);
        #1;
        mem_load = 1'b0;
        ifb.req  = '0;
        rst      = 1'b0;

        // pure round robin with MAX_HOLD=1
        step_b(3'b111, 3'b001, "rr_g0");
        step_b(3'b111, 3'b010, "rr_g1");
        step_b(3'b111, 3'b100, "rr_g2");
        step_b(3'b111, 3'b001, "rr_g0_again");
        ifb.req = '0;

        // sticky streak of 4, then rotation
        a_addr[0] = 4'd1; a_addr[1] = 4'd2; a_addr[2] = 4'd0;
        step_a(3'b001, 3'b000, 3'b001, "hold_c0");
        step_a(3'b001, 3'b000, 3'b001, "hold_c1");
        step_a(3'b011, 3'b000, 3'b001, "hold_c2");
        step_a(3'b011, 3'b000, 3'b001, "hold_c3");
        step_a(3'b011, 3'b000, 3'b010, "hold_rotate");
        step_a(3'b001, 3'b000, 3'b001, "hold_back0");
        step_a(3'b000, 3'b000, 3'b000, "hold_none");

        // write then read of the same address by another requester
        a_addr[1] = 4'd3; a_wdata[1] = 8'hA5;
        step_a(3'b010, 3'b010, 3'b010, "wr1_addr3");
        a_addr[2] = 4'd3;
        step_a(3'b100, 3'b000, 3'b100, "rd2_addr3");

        // single requester streaming 10 reads
        for (int i = 0; i < 10; i++) begin
            a_addr[2] = 4'(i);
            step_a(3'b100, 3'b000, 3'b100, "single2");
        end
        ifa.req = '0;
        @(negedge clk);
        check("drop_busy_rvalid", {31'b0, ifa.busy}, 32'h1);
        check("drop_gnt", {29'b0, ifa.gnt}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drop_state_idle", {31'b0, state_a}, {31'b0, ARB_IDLE});
        check("drop_busy_low", {31'b0, ifa.busy}, 32'h0);
        @(posedge clk);
        #1;

        // reset in the middle of a granted read
        a_addr[0] = 4'd5;
        ifa.req_addr[3:0] = a_addr[0];
        ifa.req    = 3'b001;
        ifa.req_we = 3'b000;
        @(negedge clk);
        check("pre_rst_gnt", {29'b0, ifa.gnt}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_gnt", {29'b0, ifa.gnt}, 32'h0);
        check("mid_rst_cs", {31'b0, ifa.sram_cs}, 32'h0);
        check("mid_rst_state", {31'b0, state_a}, {31'b0, ARB_IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_a(3'b111, 3'b000, 3'b001, "post_rst_first");
        ifa.req = '0;
        repeat (2) @(posedge clk);
        #1;

`ifdef SRAM_ARB_LOCK_EN
        // locked owner keeps the port past MAX_HOLD
        a_addr[0] = 4'd9; a_addr[1] = 4'd10;
        set_lock(3'b001);
        step_a(3'b001, 3'b000, 3'b001, "lock_c0");
        for (int i = 0; i < 5; i++) step_a(3'b011, 3'b000, 3'b001, "lock_keep");
        set_lock(3'b000);
        step_a(3'b011, 3'b000, 3'b010, "lock_release");
        ifa.req = '0;
        repeat (2) @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("end_q_a_empty", 32'(exp_q_a.size()), 32'h0);
        check("end_q_b_empty", 32'(exp_q_b.size()), 32'h0);
        check("end_busy_a", {31'b0, ifa.busy}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
